// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcodes, FSM states and control encodings for the multicycle
// RV32I control unit.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc_a;
        logic       alusrc_b;
    } alu_t;

    typedef struct packed {
        logic       mem_req;
        logic       memread;
        logic       memwrite;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        alu_t       alu;
        logic       memtoreg;
        logic       link;
        logic       regwrite;
    } ctrl_t;

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero,
                                          input logic lt,
                                          input logic ltu);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_imm_gen.sv
// Combinational RV32I immediate decoder (I/S/B/U/J), sign-extended
// to XLEN bits.
module imm_gen
    import multicycle_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        unique case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                raw = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                raw = {{19{inst[31]}}, inst[31], inst[7],
                       inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                raw = {inst[31:12], 12'h000};
            OPC_JAL:
                raw = {{11{inst[31]}}, inst[31], inst[19:12],
                       inst[20], inst[30:21], 1'b0};
            default:
                raw = '0;
        endcase
    end

    assign imm = XLEN'(signed'(raw));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define MULTICYCLE_CTRL_TRAP_EN to add the TRAP state and trap ports.
module multicycle_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             mem_ready,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             alu_ltu,
    output logic             mem_req,
    output logic             memread,
    output logic             memwrite,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       aluop,
    output logic             alusrc_a,
    output logic             alusrc_b,
    output logic             memtoreg,
    output logic             link,
    output logic             regwrite,
    output logic [XLEN-1:0]  imm,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    output logic             trap,
    input  logic             trap_ack
`endif
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t          state;
    logic            run;
    ctrl_t           c;
    alu_t            a;
    logic [XLEN-1:0] imm_d;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load, is_store, is_op, is_opimm;
    logic            is_lui, is_auipc, is_branch, is_jal, is_jalr;
    logic            br_ok, legal, taken, retire;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign is_load   = opcode == OPC_LOAD;
    assign is_store  = opcode == OPC_STORE;
    assign is_op     = opcode == OPC_OP;
    assign is_opimm  = opcode == OPC_OP_IMM;
    assign is_lui    = opcode == OPC_LUI;
    assign is_auipc  = opcode == OPC_AUIPC;
    assign is_branch = opcode == OPC_BRANCH;
    assign is_jal    = opcode == OPC_JAL;
    assign is_jalr   = opcode == OPC_JALR;
    assign br_ok     = funct3[2:1] != 2'b01;
    assign legal     = is_load | is_store | is_op | is_opimm | is_lui
                     | is_auipc | (is_branch & br_ok) | is_jal | is_jalr;
    assign taken     = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst),
        .imm  (imm_d)
    );

    // ALU setup depends only on the opcode and is held through MEM/WB
    always_comb begin
        a = '0;
        unique case (1'b1)
            is_op:              a.aluop = ALU_FUNC;
            is_opimm:           begin a.aluop = ALU_FUNC; a.alusrc_b = 1'b1; end
            is_lui:             begin a.aluop = ALU_PASS; a.alusrc_b = 1'b1; end
            is_auipc:           begin a.alusrc_a = 1'b1; a.alusrc_b = 1'b1; end
            is_load | is_store: begin a.aluop = ALU_ADD; a.alusrc_b = 1'b1; end
            is_branch:          a.aluop = ALU_SUB;
            is_jal:             a.alusrc_a = 1'b1;
            is_jalr:            a.alusrc_b = 1'b1;
            default:            ;
        endcase
    end

    // run stays low until the first edge after reset release
    always_comb begin
        c = '0;
        if (run) begin
            unique case (state)
                FETCH: begin
                    c.mem_req  = 1'b1;
                    c.memread  = 1'b1;
                    c.ir_write = mem_ready;
                    c.pc_write = mem_ready;
                    c.pc_src   = PC_PLUS4;
                end
                EXEC: begin
                    c.alu = a;
                    unique case (1'b1)
                        is_branch & br_ok & taken: begin
                            c.pc_write = 1'b1;
                            c.pc_src   = PC_REL;
                        end
                        is_jal: begin
                            c.pc_write = 1'b1;
                            c.pc_src   = PC_REL;
                            c.regwrite = 1'b1;
                            c.link     = 1'b1;
                        end
                        is_jalr: begin
                            c.pc_write = 1'b1;
                            c.pc_src   = PC_JALR;
                            c.regwrite = 1'b1;
                            c.link     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    c.alu      = a;
                    c.mem_req  = 1'b1;
                    c.memread  = is_load;
                    c.memwrite = is_store;
                end
                WB: begin
                    c.alu      = a;
                    c.regwrite = 1'b1;
                    c.memtoreg = is_load;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        retire = 1'b0;
        if (run) begin
            unique case (state)
                EXEC:    retire = legal ? (is_branch | is_jal | is_jalr)
                                        : !TRAP_EN;
                MEM:     retire = mem_ready & is_store;
                WB:      retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            run     <= 1'b0;
            imm     <= '0;
            instret <= '0;
        end else begin
            run <= 1'b1;
            if (retire)
                instret <= instret + CNT_W'(1);
            if (run) begin
                unique case (state)
                    FETCH:
                        if (mem_ready) state <= DECODE;
                    DECODE: begin
                        imm   <= imm_d;
                        state <= EXEC;
                    end
                    EXEC:
                        if (!legal)
                            state <= TRAP_EN ? TRAP : FETCH;
                        else if (is_load | is_store)
                            state <= MEM;
                        else if (is_branch | is_jal | is_jalr)
                            state <= FETCH;
                        else
                            state <= WB;
                    MEM:
                        if (mem_ready) state <= is_load ? WB : FETCH;
                    WB:
                        state <= FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    TRAP:
                        if (trap_ack) state <= FETCH;
`endif
                    default:
                        state <= FETCH;
                endcase
            end
        end
    end

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap = run && (state == TRAP);
`endif

    assign mem_req  = c.mem_req;
    assign memread  = c.memread;
    assign memwrite = c.memwrite;
    assign ir_write = c.ir_write;
    assign pc_write = c.pc_write;
    assign pc_src   = c.pc_src;
    assign aluop    = c.alu.aluop;
    assign alusrc_a = c.alu.alusrc_a;
    assign alusrc_b = c.alu.alusrc_b;
    assign memtoreg = c.memtoreg;
    assign link     = c.link;
    assign regwrite = c.regwrite;
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction cycle model
// plus literal checkpoints from the worked examples.
module tb_multicycle_control;
    import multicycle_ctrl_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      inst = '0;
    logic             mem_ready = 1'b0;
    logic             alu_zero = 1'b0;
    logic             alu_lt = 1'b0;
    logic             alu_ltu = 1'b0;
    logic             mem_req, memread, memwrite, ir_write, pc_write;
    logic [1:0]       pc_src, aluop;
    logic             alusrc_a, alusrc_b, memtoreg, link, regwrite;
    logic [XLEN-1:0]  imm;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state_o;
    logic             trap_v;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic trap;
    logic trap_ack = 1'b0;
    assign trap_v = trap;
`else
    assign trap_v = 1'b0;
`endif

    multicycle_control #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_req(mem_req), .memread(memread), .memwrite(memwrite),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .aluop(aluop), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .memtoreg(memtoreg), .link(link), .regwrite(regwrite),
        .imm(imm), .instret(instret), .state_o(state_o)
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , .trap(trap), .trap_ack(trap_ack)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, memread, memwrite, ir_write, pc_write;
        logic [1:0] pc_src, aluop;
        logic       alusrc_a, alusrc_b, memtoreg, link, regwrite, trap;
    } obs_t;

    int          total = 0;
    int          bad = 0;
    int          n_req = 0;
    int          n_rw = 0;
    bit          chk_en = 1'b0;
    logic [2:0]  e_state = '0;
    obs_t        e_ctl = '0;
    logic [31:0] e_imm = '0;
    logic [31:0] e_ret = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Compare process: once per cycle, late in the low phase
    always @(negedge clk) begin
        obs_t o;
        #3;
        if (chk_en) begin
            o = '{mem_req, memread, memwrite, ir_write, pc_write, pc_src,
                  aluop, alusrc_a, alusrc_b, memtoreg, link, regwrite,
                  trap_v};
            chk("state", state_o, e_state);
            chk("ctrl", o, e_ctl);
            chk("imm", imm, e_imm);
            chk("instret", instret, e_ret);
            if (mem_req) n_req++;
            if (regwrite) n_rw++;
        end
    end

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        case (i[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                return 32'($signed(i[31:20]));
            OPC_STORE:
                return 32'($signed({i[31:25], i[11:7]}));
            OPC_BRANCH:
                return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            OPC_LUI, OPC_AUIPC:
                return {i[31:12], 12'h000};
            OPC_JAL:
                return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default:
                return 32'h0;
        endcase
    endfunction

    function automatic obs_t alu_of(input logic [6:0] op);
        obs_t r = '0;
        case (op)
            OPC_OP:     r.aluop = 2'b10;
            OPC_OP_IMM: begin r.aluop = 2'b10; r.alusrc_b = 1'b1; end
            OPC_LUI:    begin r.aluop = 2'b11; r.alusrc_b = 1'b1; end
            OPC_AUIPC:  begin r.alusrc_a = 1'b1; r.alusrc_b = 1'b1; end
            OPC_LOAD, OPC_STORE: r.alusrc_b = 1'b1;
            OPC_BRANCH: r.aluop = 2'b01;
            OPC_JAL:    r.alusrc_a = 1'b1;
            OPC_JALR:   r.alusrc_b = 1'b1;
            default:    ;
        endcase
        return r;
    endfunction

    function automatic bit legal_of(input logic [31:0] i);
        case (i[6:0])
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR: return 1'b1;
            OPC_BRANCH: return !(i[14:12] == 3'b010 || i[14:12] == 3'b011);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit taken_of(input logic [2:0] f3, input logic z,
                                    input logic lt, input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic [2:0] st,
                       input obs_t c, input logic mr, input logic z = 0,
                       input logic lt = 0, input logic ltu = 0,
                       input logic ack = 0);
        @(negedge clk);
        inst = ins;
        mem_ready = mr;
        alu_zero = z;
        alu_lt = lt;
        alu_ltu = ltu;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        trap_ack = ack;
`endif
        e_state = st;
        e_ctl = c;
        @(posedge clk);
    endtask

    task automatic run(input logic [31:0] ins, input int fw = 0,
                       input int mw = 0, input logic z = 0,
                       input logic lt = 0, input logic ltu = 0,
                       input int tw = 0, input bit nz = 0);
        logic [6:0] op;
        obs_t a, c;
        bit ok, ret;
        op = ins[6:0];
        a = alu_of(op);
        ok = legal_of(ins);
        for (int k = 0; k <= fw; k++) begin
            c = '0;
            c.mem_req = 1'b1;
            c.memread = 1'b1;
            c.ir_write = (k == fw);
            c.pc_write = (k == fw);
            cyc(ins, FETCH, c, k == fw);
        end
        cyc(ins, DECODE, '0, nz);
        e_imm = imm_of(ins);
        c = a;
        ret = 1'b0;
        if (!ok) begin
`ifndef MULTICYCLE_CTRL_TRAP_EN
            ret = 1'b1;
`endif
        end else if (op == OPC_BRANCH) begin
            if (taken_of(ins[14:12], z, lt, ltu)) begin
                c.pc_write = 1'b1;
                c.pc_src = 2'd1;
            end
            ret = 1'b1;
        end else if (op == OPC_JAL || op == OPC_JALR) begin
            c.pc_write = 1'b1;
            c.pc_src = (op == OPC_JAL) ? 2'd1 : 2'd2;
            c.regwrite = 1'b1;
            c.link = 1'b1;
            ret = 1'b1;
        end
        cyc(ins, EXEC, c, nz, z, lt, ltu);
        if (ret) e_ret++;
        if (!ok) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            for (int k = 0; k <= tw; k++) begin
                c = '0;
                c.trap = 1'b1;
                cyc(ins, TRAP, c, 1'b0, 0, 0, 0, k == tw);
            end
`endif
        end else begin
            if (op == OPC_LOAD || op == OPC_STORE) begin
                for (int k = 0; k <= mw; k++) begin
                    c = a;
                    c.mem_req = 1'b1;
                    c.memread = (op == OPC_LOAD);
                    c.memwrite = (op == OPC_STORE);
                    cyc(ins, MEM, c, k == mw);
                    if (k == mw && op == OPC_STORE) e_ret++;
                end
            end
            if (op == OPC_OP || op == OPC_OP_IMM || op == OPC_LUI ||
                op == OPC_AUIPC || op == OPC_LOAD) begin
                c = a;
                c.regwrite = 1'b1;
                c.memtoreg = (op == OPC_LOAD);
                cyc(ins, WB, c, nz);
                e_ret++;
            end
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        e_state = FETCH;
        e_ctl = '0;
        chk_en = 1'b1;
        @(posedge clk);
    endtask

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'hFFC0A283;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BBAD  = 32'h0020A463;
    localparam logic [31:0] I_JAL   = 32'h001000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_LUI   = 32'h12345237;
    localparam logic [31:0] I_AUIPC = 32'hFFFFF217;
    localparam logic [31:0] I_ADDI  = 32'hFFF00093;
    localparam logic [31:0] I_SW    = 32'h0020A423;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    initial begin
        int r0, q0;
        obs_t c;
        #1;
        chk("rst_state", state_o, 3'd0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_imm", imm, 32'h0);
        chk("rst_instret", instret, 32'h0);
        repeat (2) @(negedge clk);
        release_rst();

        r0 = n_rw;
        run(I_ADD);
        #1;
        chk("add_instret", instret, 32'd1);
        chk("add_rw_cycles", n_rw - r0, 32'd1);

        q0 = n_req;
        run(I_LW, 3, 3);
        #1;
        chk("lw_imm", imm, 32'hFFFFFFFC);
        chk("lw_req_cycles", n_req - q0, 32'd8);

        run(I_BGE, 0, 0, 0, 0, 0);
        run(I_BGE, 0, 0, 0, 1, 0);
        run(I_BLTU, 0, 0, 0, 0, 1);
        run(I_BEQ, 1, 0, 1, 0, 0, 0, 1);
        run(I_BNE, 0, 0, 1, 0, 0, 0, 1);
        run(I_JAL);
        #1;
        chk("jal_imm", imm, 32'h00000800);
        run(I_JALR);
        run(I_LUI, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("lui_imm", imm, 32'h12345000);
        run(I_AUIPC);
        run(I_ADDI);
        run(I_SW, 1, 2);
        #1;
        chk("sw_instret", instret, 32'd13);
        run(I_BBAD);
        run(I_ILL, 0, 0, 0, 0, 0, 2);
        #1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        chk("ill_instret", instret, 32'd13);
`else
        chk("ill_instret", instret, 32'd15);
`endif

        // SW interrupted by reset while its write request is pending
        c = '0;
        c.mem_req = 1'b1;
        c.memread = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        cyc(I_SW, FETCH, c, 1'b1);
        cyc(I_SW, DECODE, '0, 1'b0);
        e_imm = imm_of(I_SW);
        cyc(I_SW, EXEC, alu_of(OPC_STORE), 1'b0);
        c = alu_of(OPC_STORE);
        c.mem_req = 1'b1;
        c.memwrite = 1'b1;
        cyc(I_SW, MEM, c, 1'b0);
        @(negedge clk);
        #4;
        chk("sw_req_before_rst", {mem_req, memwrite}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk_en = 1'b0;
        e_ret = '0;
        e_imm = '0;
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_memwrite", memwrite, 1'b0);
        chk("rst_mid_state", state_o, 3'd0);
        chk("rst_mid_instret", instret, 32'h0);
        repeat (2) @(negedge clk);
        release_rst();
        run(I_ADD);
        #1;
        chk("post_rst_instret", instret, 32'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
